axi_hp_rd_performance: RTL and testbench

AXI3 HP-port read-side performance and integrity tester. It is the reader counterpart of the HP write performance generator. It issues fixed-length INCR read bursts over the same address window the writer fills and accepts the returned beats. It checks each beat against the writer's data pattern, counts errors and measures total transfer time in clocks. It sits on an HP slave port of the PS. A register-file wrapper drives its control inputs and samples its status outputs.

---
 rtl/axi_hp_rd_performance.sv | 152 +++++++++++++++
 tb/tb_axi_hp_rd_performance.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_rd_performance.sv
// AXI3 HP-port read performance/integrity tester: issues 16-beat INCR read bursts
// over the writer's address window, checks the returned pattern and times the run.
module axi_hp_rd_performance #(
    parameter logic [13:0] ADDR_HI     = 14'h3FFF,
    parameter int          OUTSTANDING = 4,
    parameter int          TIME_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [10:0]       rd_num,
    output logic              busy,
    output logic              done,
    output logic [TIME_W-1:0] time_cnt,
    output logic [15:0]       err_cnt,
    output logic [14:0]       first_err_idx,
    output logic [31:0]       araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arcache,
    output logic [5:0]        arid,
    output logic [1:0]        arlock,
    output logic [2:0]        arprot,
    output logic [3:0]        arqos,
    output logic              arvalid,
    input  logic              arready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic [5:0]        rid,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OUT_MAX = 4'(OUTSTANDING);

    state_t      state, state_n;
    logic [10:0] rd_num_q;
    logic [11:0] ar_idx, ar_idx_n;
    logic [3:0]  outstanding, out_n;
    logic [15:0] exp_val;
    logic [3:0]  beat;
    logic [10:0] r_idx;
    logic [63:0] exp_data;
    logic        ar_hs, r_hs, r_last_hs, final_hs, beat_err, out_dec, issue_ok;
    logic        unused_rid;

    assign unused_rid = ^rid;

    assign arlen   = 4'hF;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;
    assign arcache = 4'b0010;
    assign arid    = 6'd0;
    assign arlock  = 2'd0;
    assign arprot  = 3'd0;
    assign arqos   = 4'd0;

    assign araddr = {ADDR_HI, ar_idx[10:0], 7'b0};
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    // A restarting start must not swallow a beat that the new test would never see.
    assign rready = (state == RUN) && !start;

    always_comb begin
        ar_hs     = arvalid && arready;
        r_hs      = rvalid && rready;
        r_last_hs = r_hs && rlast;
        final_hs  = r_last_hs && (r_idx == rd_num_q);
        exp_data  = {8'hA0, exp_val, 8'h0A, 8'hB0, exp_val, 8'h0B};
        beat_err  = (rdata != exp_data) || (rresp != 2'b00) || (rlast != (beat == 4'hF));
        ar_idx_n  = ar_idx + {11'd0, ar_hs};
        out_dec   = r_last_hs && ((outstanding != 4'd0) || ar_hs);
        out_n     = outstanding + {3'd0, ar_hs} - {3'd0, out_dec};
        // ar_idx carries one extra bit so rd_num=2047 cannot wrap back to burst 0.
        issue_ok  = (state == RUN) && !final_hs &&
                    (ar_idx_n <= {1'b0, rd_num_q}) && (out_n < OUT_MAX);
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = RUN;
        end else if ((state == RUN) && final_hs) begin
            state_n = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_num_q      <= '0;
            ar_idx        <= '0;
            outstanding   <= '0;
            arvalid       <= 1'b0;
            exp_val       <= '0;
            beat          <= '0;
            r_idx         <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            time_cnt      <= '0;
        end else if (start) begin
            rd_num_q      <= rd_num;
            ar_idx        <= '0;
            outstanding   <= '0;
            arvalid       <= 1'b0;
            exp_val       <= '0;
            beat          <= '0;
            r_idx         <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            time_cnt      <= '0;
        end else if (state == RUN) begin
            ar_idx      <= ar_idx_n;
            outstanding <= out_n;
            if (!arvalid || ar_hs) begin
                arvalid <= issue_ok;
            end
            if (time_cnt != '1) begin
                time_cnt <= time_cnt + 1'b1;
            end
            if (r_hs) begin
                exp_val <= exp_val + 16'd1;
                beat    <= rlast ? 4'd0 : beat + 4'd1;
                if (rlast) begin
                    r_idx <= r_idx + 11'd1;
                end
                if (beat_err) begin
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                    if (err_cnt == 16'd0) begin
                        first_err_idx <= {r_idx, beat};
                    end
                end
            end
        end else begin
            arvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_hp_rd_performance.sv
// Scoreboard bench: a randomizing AXI read slave feeds the tester; expected ARs and
// final status are queued at stimulus time and checked by an independent monitor.
module tb_axi_hp_rd_performance;

    typedef struct {
        int burst;
        int beat;
        int kind;
    } fault_t;

    typedef struct {
        logic [15:0] err;
        logic [14:0] first;
        int          start_cyc;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] rd_num;
    logic        busy, done;
    logic [31:0] time_cnt;
    logic [15:0] err_cnt;
    logic [14:0] first_err_idx;
    logic [31:0] araddr;
    logic [3:0]  arlen, arcache, arqos;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [5:0]  arid;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [5:0]  rid;
    logic        rlast, rvalid, rready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fault_t      faults[$];
    res_t        exp_res[$];
    logic [31:0] exp_ar[$];

    int ar_delay, credits, pend, rb, gb, beat_pos, ar_cnt;
    bit gaps, in_burst;
    bit ar_hs_s, r_hs_s, r_last_s, done_prev;
    int tb_out, ar_hs_total, last_rlast_cyc;

    axi_hp_rd_performance #(
        .ADDR_HI(14'h3FFF), .OUTSTANDING(4), .TIME_W(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rd_num(rd_num),
        .busy(busy), .done(done), .time_cnt(time_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arcache(arcache), .arid(arid),
        .arlock(arlock), .arprot(arprot), .arqos(arqos), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rid(rid),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic int faultAt(input int b, input int bt);
        foreach (faults[i]) begin
            if (faults[i].burst == b && faults[i].beat == bt) return faults[i].kind;
        end
        return 0;
    endfunction

    // Beat content follows the writer's pattern indexed by the running beat count.
    task automatic driveBeat();
        logic [15:0] g;
        int k;
        g     = 16'(gb);
        rdata = {8'hA0, g, 8'h0A, 8'hB0, g, 8'h0B};
        rresp = 2'b00;
        rlast = (beat_pos == 15);
        k     = faultAt(rb, beat_pos);
        if (k == 1) rdata = rdata ^ (64'd1 << $urandom_range(0, 63));
        else if (k == 2) rresp = 2'b10;
        else if (k == 3) rlast = 1'b1;
        rvalid = 1'b1;
    endtask

    task automatic genFaults(input int rdn);
        int     nf;
        fault_t f;
        bit     dup;
        faults.delete();
        nf = $urandom_range(0, 3);
        while (faults.size() < nf) begin
            f.burst = $urandom_range(0, rdn);
            f.beat  = $urandom_range(0, 15);
            f.kind  = $urandom_range(1, 2);
            dup = 0;
            foreach (faults[i]) if (faults[i].burst == f.burst && faults[i].beat == f.beat) dup = 1;
            if (!dup) faults.push_back(f);
        end
    endtask

    // Expected errors are simply the injected faults; the first one is the lowest burst*16+beat.
    task automatic applyStimulus(input int rdn, input int delay, input bit gap_en, input int cred);
        res_t e;
        int   best;
        @(posedge clk);
        #2;
        exp_ar.delete();
        exp_res.delete();
        for (int i = 0; i <= rdn; i++) exp_ar.push_back(32'hFFFC_0000 + 32'(i * 128));
        best = 1 << 30;
        foreach (faults[i]) if (faults[i].burst * 16 + faults[i].beat < best) best = faults[i].burst * 16 + faults[i].beat;
        e.err       = 16'(faults.size());
        e.first     = (faults.size() != 0) ? 15'(best) : 15'd0;
        e.start_cyc = cyc;
        exp_res.push_back(e);
        ar_delay = delay; gaps = gap_en; credits = cred;
        pend = 0; in_burst = 0; rb = 0; gb = 0; beat_pos = 0; ar_cnt = 0;
        rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
        tb_out = 0; ar_hs_total = 0;
        rd_num = 11'(rdn);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) checkOutput("done_timeout", done, 1);
        @(posedge clk);
        #1;
        checkOutput("ar_drained", exp_ar.size(), 0);
    endtask

    // AXI read slave: programmable AR latency, per-burst R credits, random R gaps.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pend = 0; in_burst = 0; rb = 0; gb = 0; beat_pos = 0; ar_cnt = 0;
                rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
                continue;
            end
            if (ar_hs_s) begin
                pend++;
                ar_cnt = 0;
            end
            if (arvalid) begin
                if (ar_cnt >= ar_delay) arready = 1'b1;
                else begin
                    arready = 1'b0;
                    ar_cnt++;
                end
            end else begin
                arready = 1'b0;
            end
            if (r_hs_s) begin
                gb++;
                rvalid = 1'b0;
                if (rlast) begin
                    in_burst = 0;
                    rb++;
                end else begin
                    beat_pos++;
                end
            end
            if (!rvalid) begin
                if (!in_burst && pend > 0 && credits != 0) begin
                    in_burst = 1;
                    pend--;
                    beat_pos = 0;
                    if (credits > 0) credits--;
                end
                if (in_burst && (!gaps || $urandom_range(0, 2) != 0)) driveBeat();
            end
        end
    end

    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            ar_hs_s  = arvalid && arready;
            r_hs_s   = rvalid && rready;
            r_last_s = r_hs_s && rlast;
            if (reset) begin
                ar_hs_s = 0; r_hs_s = 0; r_last_s = 0;
                done_prev = 0; tb_out = 0;
                continue;
            end
            if (arvalid && !start) begin
                if (exp_ar.size() == 0) checkOutput("ar_unexpected", arvalid, 0);
                else checkOutput("araddr", araddr, exp_ar[0]);
            end
            if (ar_hs_s) begin
                ar_hs_total++;
                checkOutput("ar_outstanding_limit", (tb_out < 4) ? 1 : 0, 1);
                checkOutput("ar_constants", {arlen, arsize, arburst, arcache, arid, arlock, arprot, arqos},
                            {4'hF, 3'b011, 2'b01, 4'b0010, 6'd0, 2'd0, 3'd0, 4'd0});
                if (exp_ar.size() != 0) void'(exp_ar.pop_front());
            end
            tb_out = tb_out + (ar_hs_s ? 1 : 0) - (r_last_s ? 1 : 0);
            if (r_last_s) last_rlast_cyc = cyc;
            if (done && !done_prev) begin
                if (exp_res.size() == 0) checkOutput("done_unexpected", done, 0);
                else begin
                    e = exp_res.pop_front();
                    checkOutput("err_cnt", err_cnt, e.err);
                    checkOutput("first_err_idx", first_err_idx, e.first);
                    checkOutput("time_cnt", time_cnt, 32'(last_rlast_cyc - e.start_cyc));
                    checkOutput("busy_at_done", busy, 0);
                    checkOutput("rready_at_done", rready, 0);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        fault_t f;
        reset = 1'b1; start = 1'b0; rd_num = '0; rid = '0;
        rvalid = 1'b0; arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_time_cnt", time_cnt, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_first_err_idx", first_err_idx, 0);
        #2 reset = 1'b0;

        $display("[TB] single burst, back-to-back beats");
        faults.delete();
        applyStimulus(0, 0, 0, -1);
        waitDone(500);

        $display("[TB] four bursts, slow arready");
        applyStimulus(3, 5, 0, -1);
        waitDone(1000);

        $display("[TB] outstanding limit with withheld R data");
        applyStimulus(9, 0, 0, 0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("hold_ar_count", ar_hs_total, 4);
        checkOutput("hold_arvalid", arvalid, 0);
        credits = 1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("release_ar_count", ar_hs_total, 5);
        credits = -1;
        waitDone(2000);

        $display("[TB] corrupt data and bad resp in burst 1");
        f.burst = 1; f.beat = 5; f.kind = 1; faults.push_back(f);
        f.burst = 1; f.beat = 9; f.kind = 2; faults.push_back(f);
        applyStimulus(1, 1, 1, -1);
        waitDone(1000);

        $display("[TB] early rlast on burst 0 beat 14");
        faults.delete();
        f.burst = 0; f.beat = 14; f.kind = 3; faults.push_back(f);
        applyStimulus(1, 0, 0, -1);
        waitDone(1000);

        $display("[TB] restart while busy");
        faults.delete();
        applyStimulus(3, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_ar_count", ar_hs_total, 4);
        applyStimulus(0, 0, 0, -1);
        checkOutput("restart_busy", busy, 1);
        checkOutput("restart_time_cnt", time_cnt, 0);
        waitDone(1000);

        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            int rdn;
            rdn = $urandom_range(0, 7);
            genFaults(rdn);
            applyStimulus(rdn, $urandom_range(0, 3), 1, -1);
            waitDone(4000);
        end

        $display("[TB] asynchronous reset mid-burst");
        faults.delete();
        applyStimulus(1, 0, 1, -1);
        for (int i = 0; i < 200 && gb < 5; i++) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("mid_rst_arvalid", arvalid, 0);
        checkOutput("mid_rst_rready", rready, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_time_cnt", time_cnt, 0);
        checkOutput("mid_rst_err_cnt", err_cnt, 0);
        checkOutput("mid_rst_first_err_idx", first_err_idx, 0);
        exp_ar.delete();
        exp_res.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        genFaults(2);
        applyStimulus(2, 2, 1, -1);
        waitDone(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
